mpc_h_v_ram_arbiter: RTL and testbench
======================================

# mpc_h_v_ram_arbiter

Burst arbiter and sequencer for the single-port, read-first h_V coefficient RAM (32-bit x 24 words) in the implicit MPC controller. It shares the one RAM port between client 0 (loader: the host/dSPACE path that refreshes h_V each control period) and client 1 (the QP solver core, which reads h_V in bursts). Each client requests a burst of consecutive addresses. The arbiter grants round-robin, then drives the RAM control signals `address0`, `ce0`, `we0` and `d0` one beat per cycle, and returns the RAM's `q0` with a valid strobe.

## Interface
- DataWidth, 32, RAM word width
- AddressWidth, 5, RAM address width
- AddressRange, 24, number of RAM words; addresses 0..AddressRange-1

Ports. Each client port group below exists for N = 0 and N = 1.
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- cN_req  in  1  burst request; held high until cN_ack
- cN_we  in  1  burst direction: 1 = write, 0 = read; sampled at grant
- cN_addr  in  AddressWidth  burst start address; sampled at grant
- cN_len  in  AddressWidth  burst length in words; sampled at grant
- cN_wdata  in  DataWidth  write data; consumed in each cycle where cN_wready = 1
- cN_ack  out  1  one-cycle pulse: burst accepted; first beat occurs this cycle
- cN_wready  out  1  write beat issued this cycle
- cN_rvalid  out  1  read data valid
- cN_rdata  out  DataWidth  read data (RAM q0)
- cN_done  out  1  one-cycle pulse coincident with the burst's last beat
- address0  out  AddressWidth  RAM address
- ce0  out  1  RAM enable
- we0  out  1  RAM write enable
- d0  out  DataWidth  RAM write data
- q0  in  DataWidth  RAM read data; valid one cycle after a ce0 = 1 beat
- err  out  1  sticky error flag; cleared only by reset

## Operation
- The FSM has two states, IDLE and BURST. Registered state: owner, we_lat, addr_cnt, beat_cnt, len_lat, rr_last, rvalid pipeline register with owner tag.
- **IDLE:** if any cN_req is high, pick a winner.
  - If only one client requests, it wins.
  - If both request, the client not equal to rr_last wins.
  - At the clock edge: latch winner into owner and rr_last, latch cN_we, and latch the start address into addr_cnt. Clear beat_cnt, latch the effective length into len_lat, and enter BURST.
- **Length and address rules:**
  - cN_len = 0 or cN_len > AddressRange is clamped to AddressRange.
  - Start address ≥ AddressRange is replaced by 0, and err is set.
- **BURST (one beat per cycle):**
  - ce0 = 1, address0 = addr_cnt, we0 = we_lat.
  - d0 = owner's wdata when we0 = 1, else 0.
  - owner's cN_wready = we0.
  - owner's cN_ack = 1 when beat_cnt = 0.
  - owner's cN_done = 1 when beat_cnt = len_lat-1.
  - After each beat: beat_cnt+1. addr_cnt+1, wrapping from AddressRange-1 to 0.
  - After the last beat, return to IDLE.
- **Read return:** for every beat with we0 = 0, the owner's cN_rvalid = 1 in the next cycle, with cN_rdata = q0. rvalid is tagged by the owner registered at issue, so the last read's data returns during the following IDLE cycle.
  - cN_rdata always carries q0. It is meaningful only while cN_rvalid = 1.
  - Write beats never produce rvalid (the read-first old data is discarded).
- **Gating:** the non-owner's ack, wready, done and rvalid are 0.
- **No preemption:** a request arriving mid-burst waits. A burst always completes unless reset asserts.

## Timing
- **Reset values:** every output is 0. State = IDLE, rr_last = 1 (client 0 wins the first tie), rvalid pipeline cleared, err = 0.
- **Reset mid-burst:** the burst is aborted immediately. ce0 and we0 drop asynchronously, and no done or rvalid is emitted.
- **Latency:** req first seen in IDLE at cycle T → ack and first beat at T+1 → last beat and done at T+len → IDLE at T+len+1. For read bursts, read data arrives at T+2..T+len+1.
- There is a minimum of one idle RAM cycle between consecutive bursts (turnaround). Sustained throughput is len/(len+1).
- A requester that keeps req high after its ack is treated as a new request at the next IDLE. Round-robin then guarantees the other client is served first if it is waiting.
- The outputs address0, ce0, we0, ack, done and wready are decoded from registered state only. d0 is combinational from the owner's wdata.

## Test plan
- **Reset defaults:** after reset → all outputs 0; no ce0 until a req.
- **Single write burst:** c0_req, we = 1, addr = 3, len = 4, wdata 0xA0..0xA3 → ce0 and we0 high for 4 cycles at addresses 3,4,5,6; ack on beat 1; done on beat 4; no rvalid.
- **Read with wrap:** c1 read, addr = 22, len = 4 → address0 sequence 22,23,0,1. c1_rvalid appears 1 cycle after each beat, rdata matches the RAM model, and the last rvalid occurs in the IDLE cycle.
- **Simultaneous requests:** c0 and c1 requests asserted simultaneously from reset → c0 granted first, c1 after one idle cycle. With both requests then held, grants alternate c0, c1, c0.
- **Clamping and error:** len = 0 → 24 beats. addr = 27 → burst starts at 0 and err = 1, sticky until reset.
- **Reset mid-burst:** reset asserted during beat 3 of a len = 8 read → ce0 = 0 immediately; no done and no further rvalid; the next request is served normally after reset release.

Source files
------------

// File: rtl/mpc_h_v_ram_arbiter.sv
// Round-robin burst arbiter sharing the single-port h_V coefficient RAM
// between the loader (client 0) and the QP solver (client 1).
module mpc_h_v_ram_arbiter #(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddressWidth = 5,
    parameter int unsigned AddressRange = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    c0_req,
    input  logic                    c0_we,
    input  logic [AddressWidth-1:0] c0_addr,
    input  logic [AddressWidth-1:0] c0_len,
    input  logic [DataWidth-1:0]    c0_wdata,
    output logic                    c0_ack,
    output logic                    c0_wready,
    output logic                    c0_rvalid,
    output logic [DataWidth-1:0]    c0_rdata,
    output logic                    c0_done,
    input  logic                    c1_req,
    input  logic                    c1_we,
    input  logic [AddressWidth-1:0] c1_addr,
    input  logic [AddressWidth-1:0] c1_len,
    input  logic [DataWidth-1:0]    c1_wdata,
    output logic                    c1_ack,
    output logic                    c1_wready,
    output logic                    c1_rvalid,
    output logic [DataWidth-1:0]    c1_rdata,
    output logic                    c1_done,
    output logic [AddressWidth-1:0] address0,
    output logic                    ce0,
    output logic                    we0,
    output logic [DataWidth-1:0]    d0,
    input  logic [DataWidth-1:0]    q0,
    output logic                    err
);

    localparam logic [AddressWidth-1:0] LastAddr  = AddressWidth'(AddressRange - 1);
    localparam logic [AddressWidth-1:0] RangeWord = AddressWidth'(AddressRange);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic                    owner_q, we_lat_q, rr_last_q, rv_q, rv_owner_q, err_q;
    logic [AddressWidth-1:0] addr_cnt_q, beat_cnt_q, len_lat_q;

    logic                    grant, winner, last_beat, ack_c, done_c;
    logic                    sel_we, bad_addr;
    logic [AddressWidth-1:0] sel_addr, sel_len, eff_len;

    // Tie goes to whichever client was not served last
    assign winner    = (c0_req && c1_req) ? ~rr_last_q : c1_req;
    assign sel_we    = winner ? c1_we   : c0_we;
    assign sel_addr  = winner ? c1_addr : c0_addr;
    assign sel_len   = winner ? c1_len  : c0_len;
    assign bad_addr  = (sel_addr >= RangeWord);
    assign eff_len   = ((sel_len == '0) || (sel_len > RangeWord)) ? RangeWord : sel_len;
    assign last_beat = (beat_cnt_q == (len_lat_q - AddressWidth'(1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant    = 1'b0;
        ce0      = 1'b0;
        we0      = 1'b0;
        address0 = '0;
        d0       = '0;
        ack_c    = 1'b0;
        done_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (c0_req || c1_req) begin
                    grant   = 1'b1;
                    state_d = BURST;
                end
            end
            BURST: begin
                ce0      = 1'b1;
                we0      = we_lat_q;
                address0 = addr_cnt_q;
                ack_c    = (beat_cnt_q == '0);
                done_c   = last_beat;
                if (we_lat_q) begin
                    d0 = owner_q ? c1_wdata : c0_wdata;
                end
                if (last_beat) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Burst bookkeeping, arbitration history and the read-return pipeline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q    <= 1'b0;
            we_lat_q   <= 1'b0;
            addr_cnt_q <= '0;
            beat_cnt_q <= '0;
            len_lat_q  <= '0;
            rr_last_q  <= 1'b1;
            rv_q       <= 1'b0;
            rv_owner_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rv_q       <= ce0 && !we0;
            rv_owner_q <= owner_q;
            if (grant) begin
                owner_q    <= winner;
                rr_last_q  <= winner;
                we_lat_q   <= sel_we;
                addr_cnt_q <= bad_addr ? '0 : sel_addr;
                beat_cnt_q <= '0;
                len_lat_q  <= eff_len;
                if (bad_addr) begin
                    err_q <= 1'b1;
                end
            end else if (state_q == BURST) begin
                beat_cnt_q <= beat_cnt_q + AddressWidth'(1);
                addr_cnt_q <= (addr_cnt_q == LastAddr) ? '0 : addr_cnt_q + AddressWidth'(1);
            end
        end
    end

    assign c0_ack    = ack_c  & ~owner_q;
    assign c1_ack    = ack_c  &  owner_q;
    assign c0_done   = done_c & ~owner_q;
    assign c1_done   = done_c &  owner_q;
    assign c0_wready = we0    & ~owner_q;
    assign c1_wready = we0    &  owner_q;
    assign c0_rvalid = rv_q   & ~rv_owner_q;
    assign c1_rvalid = rv_q   &  rv_owner_q;
    assign c0_rdata  = q0;
    assign c1_rdata  = q0;
    assign err       = err_q;

endmodule

// File: tb/tb_mpc_h_v_ram_arbiter.sv
// Bench for mpc_h_v_ram_arbiter: a read-first RAM device plus a transaction-level
// expectation of each burst (address walk, strobes, returned data).
module tb_mpc_h_v_ram_arbiter;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned RANGE = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic          c0_req, c0_we, c1_req, c1_we;
    logic [AW-1:0] c0_addr, c0_len, c1_addr, c1_len;
    logic [DW-1:0] c0_wdata, c1_wdata;
    logic          c0_ack, c0_wready, c0_rvalid, c0_done;
    logic          c1_ack, c1_wready, c1_rvalid, c1_done;
    logic [DW-1:0] c0_rdata, c1_rdata;
    logic [AW-1:0] address0;
    logic          ce0, we0, err;
    logic [DW-1:0] d0;
    logic [DW-1:0] q0 = '0;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem     [RANGE];
    logic [DW-1:0] exp_mem [RANGE];
    logic [DW-1:0] wbase   [2];
    logic          exp_err;

    logic [1:0] ack_v, done_v, wready_v, rvalid_v;
    assign ack_v    = {c1_ack, c0_ack};
    assign done_v   = {c1_done, c0_done};
    assign wready_v = {c1_wready, c0_wready};
    assign rvalid_v = {c1_rvalid, c0_rvalid};

    always #5 clk = ~clk;

    mpc_h_v_ram_arbiter #(.DataWidth(DW), .AddressWidth(AW), .AddressRange(RANGE)) dut (
        .clk(clk), .reset(reset),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_len(c0_len), .c0_wdata(c0_wdata),
        .c0_ack(c0_ack), .c0_wready(c0_wready), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata), .c0_done(c0_done),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_len(c1_len), .c1_wdata(c1_wdata),
        .c1_ack(c1_ack), .c1_wready(c1_wready), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata), .c1_done(c1_done),
        .address0(address0), .ce0(ce0), .we0(we0), .d0(d0), .q0(q0), .err(err)
    );

    // Single-port read-first RAM
    always @(posedge clk) begin
        if (ce0 && (address0 < AW'(RANGE))) begin
            q0 <= mem[address0];
            if (we0) mem[address0] <= d0;
        end
    end

    task automatic apply_reset;
        reset  = 1'b1;
        c0_req = 1'b0;
        c1_req = 1'b0;
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        exp_err = 1'b0;
        #1;
    endtask

    // Expects the ack of a burst at the next falling edge and follows it to the idle cycle
    task automatic drive_burst(input int c, input bit we, input int start, input int elen, input bit drop);
        logic [DW-1:0]   wpat;
        logic [DW-1:0]   rd;
        logic [AW+7:0]   act, exp_v;
        logic [9:0]      iact, iexp;
        for (int k = 0; k < elen; k++) begin
            @(negedge clk);
            wpat = wbase[c] + DW'(k);
            if (c == 0) c0_wdata = wpat; else c1_wdata = wpat;
            #1;
            act   = {ce0, we0, address0, ack_v[c], done_v[c], wready_v[c], rvalid_v[c],
                     ack_v[1-c] | done_v[1-c] | wready_v[1-c] | rvalid_v[1-c], err};
            exp_v = {1'b1, we, AW'((start + k) % RANGE), (k == 0), (k == elen - 1), we,
                     ((k > 0) && !we), 1'b0, exp_err};
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL beat_ctrl c%0d beat %0d got=%h expected=%h", c, k, act, exp_v);
            end
            checks++;
            if (d0 !== (we ? wpat : '0)) begin
                errors++;
                $display("FAIL beat_d0 c%0d beat %0d got=%h expected=%h", c, k, d0, (we ? wpat : '0));
            end
            if (k > 0 && !we) begin
                rd = (c == 0) ? c0_rdata : c1_rdata;
                checks++;
                if (rd !== exp_mem[(start + k - 1) % RANGE]) begin
                    errors++;
                    $display("FAIL rdata c%0d beat %0d got=%h expected=%h", c, k, rd,
                             exp_mem[(start + k - 1) % RANGE]);
                end
            end
            if (we) exp_mem[(start + k) % RANGE] = wpat;
            if (k == 0 && drop) begin
                c0_req = 1'b0;
                c1_req = 1'b0;
            end
        end
        @(negedge clk);
        #1;
        iact = {ce0, we0, c0_ack, c0_done, c0_wready, c1_ack, c1_done, c1_wready, rvalid_v[c], rvalid_v[1-c]};
        iexp = {8'b0, !we, 1'b0};
        checks++;
        if (iact !== iexp) begin
            errors++;
            $display("FAIL turnaround c%0d got=%h expected=%h", c, iact, iexp);
        end
        if (!we) begin
            rd = (c == 0) ? c0_rdata : c1_rdata;
            checks++;
            if (rd !== exp_mem[(start + elen - 1) % RANGE]) begin
                errors++;
                $display("FAIL last_rdata c%0d got=%h expected=%h", c, rd,
                         exp_mem[(start + elen - 1) % RANGE]);
            end
        end
    endtask

    task automatic issue(input int c, input bit we, input int addr, input int len);
        int elen;
        int start;
        elen  = (len == 0 || len > int'(RANGE)) ? int'(RANGE) : len;
        start = (addr >= int'(RANGE)) ? 0 : addr;
        if (addr >= int'(RANGE)) exp_err = 1'b1;
        if (c == 0) begin
            c0_req = 1'b1; c0_we = we; c0_addr = AW'(addr); c0_len = AW'(len);
        end else begin
            c1_req = 1'b1; c1_we = we; c1_addr = AW'(addr); c1_len = AW'(len);
        end
        drive_burst(c, we, start, elen, 1'b1);
    endtask

    task automatic test_reset;
        logic [AW+DW+10:0] outs;
        #1;
        outs = {c0_ack, c0_wready, c0_rvalid, c0_done, c1_ack, c1_wready, c1_rvalid, c1_done,
                address0, ce0, we0, d0, err};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h expected=0", outs);
        end
        apply_reset;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            outs = {c0_ack, c0_wready, c0_rvalid, c0_done, c1_ack, c1_wready, c1_rvalid, c1_done,
                    address0, ce0, we0, d0, err};
            checks++;
            if (outs !== '0) begin
                errors++;
                $display("FAIL idle_outputs cycle %0d got=%h expected=0", i, outs);
            end
        end
    endtask

    task automatic test_single_write;
        wbase[0] = 32'hA0;
        issue(0, 1'b1, 3, 4);
        issue(1, 1'b0, 3, 4);
    endtask

    task automatic test_read_wrap;
        issue(1, 1'b0, 22, 4);
    endtask

    task automatic test_simultaneous;
        apply_reset;
        wbase[0] = $urandom;
        c0_we = 1'b1; c0_addr = AW'(8); c0_len = AW'(2);
        c1_we = 1'b0; c1_addr = AW'(8); c1_len = AW'(3);
        c0_req = 1'b1;
        c1_req = 1'b1;
        drive_burst(0, 1'b1, 8, 2, 1'b0);
        drive_burst(1, 1'b0, 8, 3, 1'b0);
        drive_burst(0, 1'b1, 8, 2, 1'b1);
    endtask

    task automatic test_clamp_err;
        apply_reset;
        issue(0, 1'b0, 27, 0);
        issue(1, 1'b0, 5, 30);
        apply_reset;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared got=%b expected=0", err);
        end
    endtask

    task automatic test_reset_mid_burst;
        logic [AW+10:0] outs;
        c1_req = 1'b1; c1_we = 1'b0; c1_addr = AW'(2); c1_len = AW'(8);
        @(negedge clk);
        #1;
        checks++;
        if (c1_ack !== 1'b1) begin
            errors++;
            $display("FAIL mid_ack got=%b expected=1", c1_ack);
        end
        c1_req = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            outs = {c0_ack, c0_wready, c0_rvalid, c0_done, c1_ack, c1_wready, c1_rvalid, c1_done,
                    address0, ce0, we0};
            checks++;
            if (outs !== '0) begin
                errors++;
                $display("FAIL abort_outputs step %0d got=%h expected=0", i, outs);
            end
            @(negedge clk);
            #1;
        end
        reset   = 1'b0;
        exp_err = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({ce0, c1_rvalid, c1_done} !== 3'b000) begin
            errors++;
            $display("FAIL post_abort got=%b expected=000", {ce0, c1_rvalid, c1_done});
        end
        issue(0, 1'b0, 20, 5);
    endtask

    task automatic test_random;
        int c, addr, len, gap;
        bit we;
        for (int n = 0; n < 20; n++) begin
            c    = int'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(24, 31)) : int'($urandom_range(0, 23));
            len  = int'($urandom_range(0, 31));
            gap  = int'($urandom_range(0, 2));
            wbase[c] = $urandom;
            if (gap > 0) begin
                repeat (gap) @(negedge clk);
                #1;
            end
            issue(c, we, addr, len);
        end
    endtask

    initial begin
        reset    = 1'b1;
        c0_req   = 1'b0; c0_we = 1'b0; c0_addr = '0; c0_len = '0; c0_wdata = '0;
        c1_req   = 1'b0; c1_we = 1'b0; c1_addr = '0; c1_len = '0; c1_wdata = '0;
        exp_err  = 1'b0;
        wbase[0] = '0;
        wbase[1] = '0;
        for (int i = 0; i < int'(RANGE); i++) begin
            mem[i]     = $urandom;
            exp_mem[i] = mem[i];
        end
        test_reset;
        test_single_write;
        test_read_wrap;
        test_simultaneous;
        test_clamp_err;
        test_reset_mid_burst;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
